// File: rtl/dpram_pkg.sv
// Shared definitions for the DPRAM memory-access handshake (test unit and responder).
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
//
// Contents: default address/data widths, default RAM read latency and the
// responder state encoding.
package dpram_pkg;

    localparam int ADDR_W_DEF = 10;   // 1024-word RAM
    localparam int DATA_W_DEF = 16;
    localparam int RD_LAT_DEF = 1;    // 1 = unregistered q, 2 = registered q

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/dpram_port_responder.sv
// Responder for the RD/WR/Done handshake; converts one request into DPRAM port activity.
// Latency: write Done at accept+2, read Done at accept+2+RD_LAT, write+read at accept+3+RD_LAT.
// Backpressure: one request at a time; requester holds RD/WR until Done, Done holds until both drop.
//
// Ports:
//   clk, ar          clock, asynchronous active-high reset
//   RD, WR, A, DIn   request side (A/DIn sampled only at accept)
//   DOut, Done, Busy response side
//   Data, Wr_A, WE   RAM write port
//   Rd_A, Q          RAM read port (Q valid RD_LAT edges after Rd_A is captured)
module dpram_port_responder
    import dpram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF      // legal range 1..4
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DIn,
    output logic [DATA_W-1:0] DOut,
    output logic              Done,
    output logic              Busy,
    output logic [DATA_W-1:0] Data,
    output logic [ADDR_W-1:0] Wr_A,
    output logic [ADDR_W-1:0] Rd_A,
    output logic              WE,
    input  logic [DATA_W-1:0] Q
);

    // READ lasts RD_LAT+1 cycles: one to present Rd_A, RD_LAT for the RAM to answer.
    localparam logic [2:0] LP_CNT_LAST = 3'(RD_LAT);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_rd_last;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_din;
    logic               r_rd_pend;   // read requested at accept (alone or after a write)
    logic [2:0]         r_cnt;
    logic [DATA_W-1:0]  r_dout;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (WR || RD) begin
                    w_accept     = 1'b1;
                    w_next_state = WR ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // Combined request: the read-back follows the write so DOut sees the new value.
                w_next_state = r_rd_pend ? ST_READ : ST_ACK;
            end
            ST_READ: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_rd_last    = 1'b1;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!RD && !WR) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_din     <= '0;
            r_rd_pend <= 1'b0;
            r_cnt     <= 3'd0;
            r_dout    <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_addr    <= A;
                r_din     <= DIn;
                r_rd_pend <= RD;
            end

            if (r_state == ST_READ && !w_rd_last) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= 3'd0;
            end

            if (w_rd_last) begin
                r_dout <= Q;
            end
        end
    end

    // Strobes decode the state register only, so ar removes WE in the same cycle
    // and no input glitch can reach the RAM write enable.
    assign WE   = (r_state == ST_WRITE);
    assign Done = (r_state == ST_ACK);
    assign Busy = (r_state != ST_IDLE);

    // Latched request drives both RAM ports; the RAM only acts on Data/Wr_A while WE is high.
    assign Data = r_din;
    assign Wr_A = r_addr;
    assign Rd_A = r_addr;
    assign DOut = r_dout;

endmodule

// File: tb/tb_dpram_port_responder.sv
// Bench: two responders (RD_LAT=1 and RD_LAT=2) share one requester and each owns a RAM model.
// Latency: n/a.
// Backpressure: requester holds RD/WR until both instances show Done.
module tb_dpram_port_responder;

    logic        clk = 1'b0;
    logic        ar;
    logic        req_rd;
    logic        req_wr;
    logic [9:0]  req_a;
    logic [15:0] req_din;
    logic        mem_clr;

    logic [1:0][15:0] dout_w;
    logic [1:0][15:0] data_w;
    logic [1:0][15:0] q_w;
    logic [1:0][9:0]  wr_a_w;
    logic [1:0][9:0]  rd_a_w;
    logic [1:0]       done_w;
    logic [1:0]       busy_w;
    logic [1:0]       we_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [15:0] mem [1024];
        logic [9:0]  apipe [g+1];

        dpram_port_responder #(
            .ADDR_W (10),
            .DATA_W (16),
            .RD_LAT (g + 1)
        ) u_dut (
            .clk  (clk),
            .ar   (ar),
            .RD   (req_rd),
            .WR   (req_wr),
            .A    (req_a),
            .DIn  (req_din),
            .DOut (dout_w[g]),
            .Done (done_w[g]),
            .Busy (busy_w[g]),
            .Data (data_w[g]),
            .Wr_A (wr_a_w[g]),
            .Rd_A (rd_a_w[g]),
            .WE   (we_w[g]),
            .Q    (q_w[g])
        );

        // RAM: read address captured each edge, data appears g+1 edges later.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int j = 0; j < 1024; j++) mem[j] <= 16'h0;
                for (int j = 0; j <= g; j++) apipe[j] <= 10'h0;
            end else begin
                if (we_w[g]) mem[wr_a_w[g]] <= data_w[g];
                apipe[0] <= rd_a_w[g];
                for (int j = 1; j <= g; j++) apipe[j] <= apipe[j-1];
            end
        end
        assign q_w[g] = mem[apipe[g]];
    end

    // Reference model state
    logic [15:0] ref_mem [1024];
    logic [15:0] ref_dout;

    // Results of the last transaction
    int          r_first [2];
    int          r_wecnt [2];
    logic [9:0]  r_we_a  [2];
    logic [15:0] r_we_d  [2];
    logic [1:0]  r_busy_mid;
    logic [1:0]  r_done_after;
    logic [1:0]  r_busy_after;

    // Cycles from accept edge to first Done-high cycle, from the protocol rules.
    function automatic int exp_lat(input logic rd, input logic wr, input int lat);
        if (wr && rd) return 3 + lat;
        if (wr)       return 2;
        return 2 + lat;
    endfunction

    // Drives one request, measures Done latency and WE activity, then drops the request.
    task automatic run_txn(input logic rd, input logic wr, input logic [9:0] a, input logic [15:0] d,
                           input logic mutate, input logic [9:0] ma, input logic [15:0] md,
                           input int hold);
        int n;
        int held;
        @(negedge clk);
        ar = 1'b0; req_rd = rd; req_wr = wr; req_a = a; req_din = d;
        for (int i = 0; i < 2; i++) begin
            r_first[i] = 0; r_wecnt[i] = 0; r_we_a[i] = '0; r_we_d[i] = '0;
        end
        n = 0; held = 0;
        while (n < 40 && held <= hold) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                r_busy_mid = busy_w;
                if (mutate) begin req_a = ma; req_din = md; end
            end
            for (int i = 0; i < 2; i++) begin
                if (we_w[i]) begin r_wecnt[i]++; r_we_a[i] = wr_a_w[i]; r_we_d[i] = data_w[i]; end
                if (done_w[i] && r_first[i] == 0) r_first[i] = n;
            end
            if (r_first[0] != 0 && r_first[1] != 0) held++;
        end
        req_rd = 1'b0; req_wr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) if (we_w[i]) r_wecnt[i]++;
        r_done_after = done_w;
        r_busy_after = busy_w;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            checks++; if (dout_w[i] !== 16'h0) begin errors++; $display("FAIL rst_dout inst%0d: got %h exp 0000", i, dout_w[i]); end
            checks++; if ({done_w[i], busy_w[i], we_w[i]} !== 3'b000) begin errors++; $display("FAIL rst_flags inst%0d: got %b exp 000", i, {done_w[i], busy_w[i], we_w[i]}); end
            checks++; if ({data_w[i], wr_a_w[i], rd_a_w[i]} !== 36'h0) begin errors++; $display("FAIL rst_ports inst%0d: got %h exp 0", i, {data_w[i], wr_a_w[i], rd_a_w[i]}); end
        end
        @(negedge clk); ar = 1'b0;
        @(negedge clk);
        checks++; if (busy_w !== 2'b00) begin errors++; $display("FAIL idle_busy: got %b exp 00", busy_w); end
    endtask

    task automatic test_write;
        run_txn(1'b0, 1'b1, 10'h005, 16'hBEEF, 1'b0, '0, '0, 0);
        ref_mem[10'h005] = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            checks++; if (r_first[i] != 2) begin errors++; $display("FAIL wr_done_lat inst%0d: got %0d exp 2", i, r_first[i]); end
            checks++; if (r_wecnt[i] != 1) begin errors++; $display("FAIL wr_we_count inst%0d: got %0d exp 1", i, r_wecnt[i]); end
            checks++; if (r_we_a[i] !== 10'h005 || r_we_d[i] !== 16'hBEEF) begin errors++; $display("FAIL wr_port inst%0d: got %h/%h exp 005/beef", i, r_we_a[i], r_we_d[i]); end
            checks++; if (r_done_after[i] !== 1'b0) begin errors++; $display("FAIL wr_done_drop inst%0d: got %b exp 0", i, r_done_after[i]); end
            checks++; if (dout_w[i] !== ref_dout) begin errors++; $display("FAIL wr_dout_hold inst%0d: got %h exp %h", i, dout_w[i], ref_dout); end
        end
        checks++; if (r_busy_mid !== 2'b11) begin errors++; $display("FAIL wr_busy: got %b exp 11", r_busy_mid); end
    endtask

    task automatic test_read(input logic [9:0] a);
        run_txn(1'b1, 1'b0, a, 16'h0, 1'b0, '0, '0, 0);
        ref_dout = ref_mem[a];
        for (int i = 0; i < 2; i++) begin
            checks++; if (r_first[i] != exp_lat(1'b1, 1'b0, i + 1)) begin errors++; $display("FAIL rd_done_lat inst%0d: got %0d exp %0d", i, r_first[i], exp_lat(1'b1, 1'b0, i + 1)); end
            checks++; if (dout_w[i] !== ref_dout) begin errors++; $display("FAIL rd_dout inst%0d addr %h: got %h exp %h", i, a, dout_w[i], ref_dout); end
            checks++; if (r_wecnt[i] != 0) begin errors++; $display("FAIL rd_we_count inst%0d: got %0d exp 0", i, r_wecnt[i]); end
            checks++; if (r_busy_after[i] !== 1'b0) begin errors++; $display("FAIL rd_busy_after inst%0d: got %b exp 0", i, r_busy_after[i]); end
        end
    endtask

    task automatic test_write_read;
        run_txn(1'b1, 1'b1, 10'h3FF, 16'h1234, 1'b0, '0, '0, 0);
        ref_mem[10'h3FF] = 16'h1234;
        ref_dout = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            checks++; if (r_first[i] != exp_lat(1'b1, 1'b1, i + 1)) begin errors++; $display("FAIL wrrd_done_lat inst%0d: got %0d exp %0d", i, r_first[i], exp_lat(1'b1, 1'b1, i + 1)); end
            checks++; if (r_wecnt[i] != 1 || r_we_a[i] !== 10'h3FF) begin errors++; $display("FAIL wrrd_we inst%0d: got %0d@%h exp 1@3ff", i, r_wecnt[i], r_we_a[i]); end
            checks++; if (dout_w[i] !== 16'h1234) begin errors++; $display("FAIL wrrd_dout inst%0d: got %h exp 1234", i, dout_w[i]); end
        end
    endtask

    task automatic test_addr_ignore;
        // A/DIn change right after accept; WR held through several ACK cycles.
        run_txn(1'b0, 1'b1, 10'h010, 16'h00AA, 1'b1, 10'h000, 16'hFFFF, 3);
        ref_mem[10'h010] = 16'h00AA;
        for (int i = 0; i < 2; i++) begin
            checks++; if (r_wecnt[i] != 1) begin errors++; $display("FAIL hold_we_count inst%0d: got %0d exp 1", i, r_wecnt[i]); end
            checks++; if (r_we_a[i] !== 10'h010 || r_we_d[i] !== 16'h00AA) begin errors++; $display("FAIL ignore_port inst%0d: got %h/%h exp 010/00aa", i, r_we_a[i], r_we_d[i]); end
        end
        test_read(10'h000);
        test_read(10'h010);
    endtask

    task automatic test_reset_mid;
        // Reset during READ
        @(negedge clk); req_rd = 1'b1; req_a = 10'h005;
        @(negedge clk);
        ar = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({done_w[i], busy_w[i]} !== 2'b00) begin errors++; $display("FAIL arst_rd_flags inst%0d: got %b exp 00", i, {done_w[i], busy_w[i]}); end
            checks++; if (dout_w[i] !== 16'h0) begin errors++; $display("FAIL arst_rd_dout inst%0d: got %h exp 0000", i, dout_w[i]); end
        end
        ref_dout = 16'h0;
        req_rd = 1'b0;
        // Reset during WRITE: WE must drop without waiting for a clock
        @(negedge clk); ar = 1'b0; req_wr = 1'b1; req_a = 10'h020; req_din = 16'h5555;
        @(negedge clk);
        checks++; if (we_w !== 2'b11) begin errors++; $display("FAIL arst_wr_pre: got %b exp 11", we_w); end
        ar = 1'b1; #1;
        checks++; if (we_w !== 2'b00 || busy_w !== 2'b00) begin errors++; $display("FAIL arst_wr_we: got we %b busy %b exp 00/00", we_w, busy_w); end
        // Read held across reset release
        req_wr = 1'b0; req_rd = 1'b1; req_a = 10'h005;
        @(negedge clk);
        run_txn(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, '0, '0, 0);
        ref_dout = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            checks++; if (r_first[i] != 2 + i + 1) begin errors++; $display("FAIL arst_release_lat inst%0d: got %0d exp %0d", i, r_first[i], 3 + i); end
            checks++; if (dout_w[i] !== 16'hBEEF) begin errors++; $display("FAIL arst_reread inst%0d: got %h exp beef", i, dout_w[i]); end
        end
        // Put the possibly half-written word in a known state
        run_txn(1'b0, 1'b1, 10'h020, 16'h5555, 1'b0, '0, '0, 0);
        ref_mem[10'h020] = 16'h5555;
    endtask

    task automatic test_random;
        logic rd, wr;
        logic [9:0] a;
        logic [15:0] d;
        int hold;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: begin rd = 1'b1; wr = 1'b0; end
                1: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
            d = 16'($urandom);
            hold = $urandom_range(0, 2);
            run_txn(rd, wr, a, d, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom), hold);
            if (wr) ref_mem[a] = d;
            if (rd) ref_dout = ref_mem[a];
            for (int i = 0; i < 2; i++) begin
                checks++; if (r_first[i] != exp_lat(rd, wr, i + 1)) begin errors++; $display("FAIL rnd_lat t%0d inst%0d: got %0d exp %0d", t, i, r_first[i], exp_lat(rd, wr, i + 1)); end
                checks++; if (r_wecnt[i] != int'(wr)) begin errors++; $display("FAIL rnd_we t%0d inst%0d: got %0d exp %0d", t, i, r_wecnt[i], int'(wr)); end
                if (wr) begin
                    checks++; if (r_we_a[i] !== a || r_we_d[i] !== d) begin errors++; $display("FAIL rnd_port t%0d inst%0d: got %h/%h exp %h/%h", t, i, r_we_a[i], r_we_d[i], a, d); end
                end
                checks++; if (dout_w[i] !== ref_dout) begin errors++; $display("FAIL rnd_dout t%0d inst%0d: got %h exp %h", t, i, dout_w[i], ref_dout); end
                checks++; if (r_done_after[i] !== 1'b0) begin errors++; $display("FAIL rnd_done_drop t%0d inst%0d: got %b exp 0", t, i, r_done_after[i]); end
            end
        end
    endtask

    initial begin
        ar = 1'b1; mem_clr = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_a = '0; req_din = '0;
        for (int j = 0; j < 1024; j++) ref_mem[j] = 16'h0;
        ref_dout = 16'h0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        test_write();
        test_read(10'h005);
        test_write_read();
        test_addr_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_port_responder.md
# dpram_port_responder

Responder end of the RD/WR/Done memory-access handshake driven by the MemRWTest unit. It accepts single read or write requests, translates them into dual-port RAM port signals, and returns read data on DOut. It absorbs the RAM read latency and completes each transfer with a four-phase Done acknowledge. It sits between the test unit and the DPRAM instance.

## Interface
- ADDR_W, 10, address width (1024-word RAM)
- DATA_W, 16, data width
- RD_LAT, 1, clock edges from RAM read-address capture to valid Q (1 = unregistered q, 2 = registered q); legal range 1..4
- clk  in  1  system clock; all state changes on rising edge
- ar  in  1  reset, asynchronous, active-high
- RD  in  1  read request (level, held until Done)
- WR  in  1  write request (level, held until Done)
- A  in  ADDR_W  request address; sampled only at accept
- DIn  in  DATA_W  write data; sampled only at accept
- DOut  out  DATA_W  last read result; held until next read completes
- Done  out  1  acknowledge; high until RD and WR are both low
- Busy  out  1  high whenever state is not IDLE
- Data  out  DATA_W  RAM write data
- Wr_A  out  ADDR_W  RAM write address
- Rd_A  out  ADDR_W  RAM read address
- WE  out  1  RAM write enable
- Q  in  DATA_W  RAM read data

## Operation
- States: IDLE, WRITE, READ, ACK.
- IDLE: if WR or RD is high at a rising edge, latch A and DIn and latch the request type (write, read, or both).
  - If WR is high: go to WRITE.
  - Else: go to READ.
- WRITE (1 cycle): WE=1, Wr_A=latched A, Data=latched DIn.
  - If RD was also latched: go to READ.
  - Else: go to ACK.
- READ (RD_LAT+1 cycles, counted by an internal counter): Rd_A=latched A.
  - On the last cycle, register DOut <= Q and go to ACK.
- ACK: Done=1. Return to IDLE on the first edge where RD=0 and WR=0. No new request is accepted until then.
- RD and WR both high at accept: perform the write, then read back the same address. DOut carries the newly written value. One Done covers both operations.
- A and DIn changes after accept are ignored.
- Address wrap is not applicable. Every ADDR_W-bit address is legal, and 0x3FF behaves like any other address.
- WE is decoded from the state register only. It is never combinational from the inputs.

## Timing
- Reset values: state IDLE, Done 0, Busy 0, WE 0, DOut 0, Data 0, Wr_A 0, Rd_A 0, counter 0.
- Request accepted at edge k.
- Write:
  - WE high during cycle k+1.
  - Done high from cycle k+2.
- Read:
  - Rd_A valid from cycle k+1.
  - DOut updated at the end of cycle k+1+RD_LAT.
  - Done high from cycle k+2+RD_LAT.
- Write plus read: Done high from cycle k+3+RD_LAT.
- Done falls one cycle after the edge where RD and WR are both sampled low.
- Back-to-back transfers: minimum one IDLE cycle between Done falling and the next accept.
- ar asserted mid-operation: all outputs return to reset values immediately, including WE dropping within the same cycle.
  - A write whose WRITE cycle is cut short by ar is not guaranteed to commit.
  - DOut is cleared.
- Request held high across ar release: accepted at the first edge after release.

## Structure
- Shared package dpram_pkg: ADDR_W and DATA_W defaults, the state encoding (IDLE, WRITE, READ, ACK), and the RD_LAT default. The package is reused by MemRWTest and the top level.
- Flat module. The latency counter is a 3-bit register inside the block. No sub-module is warranted.

## Test plan
- Reset, then WR=1, A=0x005, DIn=0xBEEF:
  - Exactly one WE pulse with Wr_A=0x005 and Data=0xBEEF.
  - Done rises 2 cycles after accept.
  - Dropping WR clears Done one cycle later.
- After the write above, RD=1, A=0x005:
  - DOut=0xBEEF and Done rise 2+RD_LAT cycles after accept.
  - Repeat with RD_LAT=2: one extra cycle.
- RD=1 and WR=1 together, A=0x3FF, DIn=0x1234:
  - WE pulse first, then read of 0x3FF.
  - DOut=0x1234; a single Done.
- Change A to 0x000 and DIn to 0xFFFF one cycle after accepting a write to 0x010 with 0x00AA:
  - RAM receives Wr_A=0x010, Data=0x00AA.
  - Holding WR high through ACK causes no second write.
- ar pulsed during READ of 0x005:
  - Done, Busy, and DOut return to 0 immediately.
  - After release, a fresh read of 0x005 returns 0xBEEF normally.
